aes_inv_subbytes_seq: RTL and testbench
=======================================

// Module: aes_inv_subbytes_seq
// PURPOSE
//  Sequential AES InvSubBytes engine for the decrypt path of the 8-bit-datapath AES core.
//  Accepts one 128-bit state and replaces each byte with its inverse S-box value, BYTES_PER_CYCLE bytes per clock.
//  Returns the result over a valid/ready handshake.
//  Sits between AddRoundKey/InvMixColumns and the round register; counterpart of the forward S-box lookup.
// PARAMETERS
//  BYTES_PER_CYCLE  1  bytes substituted per clock; legal values 1, 2, 4; latency = 16/BYTES_PER_CYCLE
// PORTS
//  clk        in   1    single clock, all logic on rising edge
//  reset_n    in   1    synchronous, active-low reset
//  in_valid   in   1    in_state valid
//  in_ready   out  1    engine can accept a block
//  in_state   in   128  input state; byte 0 = [127:120], byte 15 = [7:0] (FIPS-197 column-major order)
//  out_valid  out  1    out_state holds a finished block
//  out_ready  in   1    consumer accepts out_state
//  out_state  out  128  InvSubBytes(in_state), same byte order
//  busy       out  1    1 while in SUB
// BEHAVIOUR
//  Reset (reset_n=0 at a rising edge):
//   - FSM=IDLE, byte counter=0, state register=0.
//   - out_valid=0, busy=0, out_state=0; in_ready=1 from the first cycle after reset.
//  FSM states: IDLE, SUB, DONE.
//   - IDLE: in_ready=1. On in_valid&&in_ready, capture in_state, counter=0, go to SUB.
//   - SUB: each edge replaces bytes [cnt .. cnt+BPC-1] in place; counter += BPC.
//     The edge that writes byte 15 moves to DONE. in_ready=0. in_valid is ignored.
//   - DONE: out_valid=1; out_state and out_valid are held stable until out_valid&&out_ready.
//  Latency: handshake at edge E0 -> out_valid=1 after edge E(16/BPC); 16 clocks at the default.
//  Throughput:
//   - in_ready = (FSM==IDLE) || (FSM==DONE && out_ready).
//   - Simultaneous out handshake and in handshake in DONE: output retires, new block is captured, FSM goes to SUB the same edge.
//   - No bubble.
//  DONE && out_ready && !in_valid -> IDLE; out_valid=0 next cycle.
//  Backpressure: out_ready=0 holds DONE indefinitely; no data loss or overwrite.
//  Reset mid-operation (SUB or DONE): block is discarded, all outputs return to reset values next cycle.
//  Inverse S-box: 256x8 constant table, combinational, one instance per substituted byte lane.
//  Counter: 4-bit; it never wraps because the FSM leaves SUB at cnt+BPC==16.
// CONFIGURATION
//  `AES_INV_SHIFTROWS_EN defined:
//   - out_state = InvShiftRows(InvSubBytes(in_state)).
//   - Output byte 4*((c+r)%4)+r takes substituted byte 4c+r.
//   - Pure output permutation; latency and handshake are unchanged.
//  Macro undefined: out_state = InvSubBytes(in_state) only. InvShiftRows is done elsewhere in the round.
// STRUCTURE
//  aes_pkg (shared):
//   - typedef enum logic[1:0] {IDLE,SUB,DONE} inv_sub_state_t
//   - localparam AES_BLOCK_BYTES=16
//   - function inv_shift_rows(logic[127:0]) so the round logic reuses it.
//  Sub-module: aes_inv_sbox8 (8-bit in -> 8-bit out, combinational inverse S-box ROM).
//   - Instantiated BYTES_PER_CYCLE times via generate.
//  Top holds the FSM, counter, 128-bit state register, byte-lane mux/demux and optional output permutation.
// TESTING
//  1. Ciphertext-side vector, default parameter:
//     in_state=637c777bf26b6fc53001672bfed7ab76 -> out_state=000102030405060708090a0b0c0d0e0f,
//     out_valid exactly 16 clocks after the accept.
//  2. Table corners: all-bytes 63 -> all 00; all 00 -> all 52; all 16 -> all ff; all ff -> all 7d.
//  3. Backpressure: hold out_ready=0 for 20 cycles in DONE.
//     out_state is stable, in_ready=0, in_valid pulses are ignored; release -> single transfer.
//  4. Back-to-back: in_valid and out_ready held high with two blocks.
//     Second accept coincides with the first retire; second out_valid 16 clocks later.
//  5. Reset mid-SUB at cnt=7: next cycle out_valid=0, busy=0, in_ready=1.
//     A new block then completes correctly.
//  6. With `AES_INV_SHIFTROWS_EN and BYTES_PER_CYCLE=4:
//     vector 1 input -> 000d0a0704010e0b0805020f0c090603 after 4 clocks.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the round logic: block size, InvSubBytes FSM states
// and the InvShiftRows byte permutation (used when AES_INV_SHIFTROWS_EN is defined).
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } inv_sub_state_t;

    // Byte 4c+r of the input lands in output byte 4*((c+r)%4)+r; byte 0 is [127:120].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * ((c + row) % 4) + row) -: 8] = s[127 - 8 * (4 * c + row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_sbox8.sv
// Combinational AES inverse S-box: one byte in, its inverse substitution out.
module aes_inv_sbox8 (
    input  logic [7:0] byte_val,
    output logic [7:0] inv_byte
);

    // Entry for input 8'h00 sits in the top byte, so row 0 of the usual table reads first.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign inv_byte = INV_SBOX[{~byte_val, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_subbytes_seq.sv
// Sequential InvSubBytes engine, BYTES_PER_CYCLE bytes per clock, valid/ready on both sides.
// Defining AES_INV_SHIFTROWS_EN applies InvShiftRows to the output as a pure permutation.
module aes_inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    inv_sub_state_t                      state_q;
    logic [3:0]                          cnt_q;
    logic [0:AES_BLOCK_BYTES-1][7:0]     blk_q;
    logic [7:0]                          lane_in  [BYTES_PER_CYCLE];
    logic [7:0]                          lane_out [BYTES_PER_CYCLE];
    logic                                last_step;

    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        assign lane_in[l] = blk_q[cnt_q + 4'(l)];

        aes_inv_sbox8 u_sbox (
            .byte_val (lane_in[l]),
            .inv_byte (lane_out[l])
        );
    end

    assign last_step = (5'(cnt_q) + 5'(BYTES_PER_CYCLE)) == 5'(AES_BLOCK_BYTES);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == SUB);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        blk_q   <= in_state;
                        cnt_q   <= '0;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
                        blk_q[cnt_q + 4'(l)] <= lane_out[l];
                    end
                    cnt_q <= cnt_q + 4'(BYTES_PER_CYCLE);
                    if (last_step) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // Retire and accept on the same edge so back-to-back blocks see no bubble.
                    if (out_ready) begin
                        if (in_valid) begin
                            blk_q   <= in_state;
                            cnt_q   <= '0;
                            state_q <= SUB;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AES_INV_SHIFTROWS_EN
    assign out_state = inv_shift_rows(blk_q);
`else
    assign out_state = blk_q;
`endif

endmodule

// File: tb/tb_aes_inv_subbytes_seq.sv
// Directed self-checking bench for aes_inv_subbytes_seq (default and BYTES_PER_CYCLE=4 instances).
module tb_aes_inv_subbytes_seq;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_state, b_out_state;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] V1_IN = 128'h637c777bf26b6fc53001672bfed7ab76;
`ifdef AES_INV_SHIFTROWS_EN
    localparam logic [127:0] V1_EXP = 128'h000d0a0704010e0b0805020f0c090603;
`else
    localparam logic [127:0] V1_EXP = 128'h000102030405060708090a0b0c0d0e0f;
`endif

    always #5 clk = ~clk;

    aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    aes_inv_subbytes_seq #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_state  (b_in_state),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_state (b_out_state),
        .busy      (b_busy)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
        int lat;
        in_state = din;
        in_valid = 1'b1;
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_busy"}, 128'(busy), 128'd1);
        wait_done(lat);
        check_eq({tag, "_latency"}, 128'(lat), 128'd16);
        check_eq({tag, "_data"}, out_state, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_retired"}, 128'(out_valid), 128'd0);
        check_eq({tag, "_idle_ready"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] corner_in  [4];
        logic [7:0] corner_out [4];
        int lat;
        int bad;

        corner_in  = '{8'h63, 8'h00, 8'h16, 8'hff};
        corner_out = '{8'h00, 8'h52, 8'hff, 8'h7d};

        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_state    = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_in_state  = '0;
        tick();
        tick();
        check_eq("rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        check_eq("rst_in_ready", 128'(in_ready), 128'd1);
        check_eq("rst_out_state", out_state, 128'd0);
        check_eq("rst4_out_valid", 128'(b_out_valid), 128'd0);
        reset_n = 1'b1;
        tick();

        run_block("v1", V1_IN, V1_EXP);

        for (int i = 0; i < 4; i++) begin
            run_block($sformatf("corner%0d", i), {16{corner_in[i]}}, {16{corner_out[i]}});
        end

        // Backpressure: hold DONE for 20 cycles while poking in_valid
        in_state = {16{8'h00}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_done(lat);
        check_eq("bp_latency", 128'(lat), 128'd16);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_state = {16{8'h16}} ^ 128'(i);
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
                out_state !== {16{8'h52}})
                bad++;
        end
        in_valid = 1'b0;
        check_eq("bp_hold_bad_cycles", 128'(bad), 128'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("bp_release_valid", 128'(out_valid), 128'd0);
        check_eq("bp_release_busy", 128'(busy), 128'd0);
        tick();
        tick();
        tick();
        check_eq("bp_single_transfer", 128'(out_valid), 128'd0);

        // Back-to-back: retire of block A coincides with accept of block B
        in_state  = V1_IN;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_state = {16{8'hff}};
        wait_done(lat);
        check_eq("b2b_a_latency", 128'(lat), 128'd16);
        check_eq("b2b_a_in_ready", 128'(in_ready), 128'd1);
        check_eq("b2b_a_data", out_state, V1_EXP);
        tick();
        in_valid = 1'b0;
        check_eq("b2b_b_accepted", 128'(busy), 128'd1);
        check_eq("b2b_a_retired", 128'(out_valid), 128'd0);
        wait_done(lat);
        check_eq("b2b_b_latency", 128'(lat), 128'd16);
        check_eq("b2b_b_data", out_state, {16{8'h7d}});
        tick();
        out_ready = 1'b0;
        check_eq("b2b_b_retired", 128'(out_valid), 128'd0);

        // Reset in the middle of SUB with the counter at 7
        in_state = {16{8'h16}};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check_eq("mid_busy", 128'(busy), 128'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check_eq("mid_rst_busy", 128'(busy), 128'd0);
        check_eq("mid_rst_in_ready", 128'(in_ready), 128'd1);
        check_eq("mid_rst_out_state", out_state, 128'd0);
        run_block("post_rst", V1_IN, V1_EXP);

        // Four bytes per clock: latency 4
        b_in_state = V1_IN;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        lat = 0;
        while (b_out_valid !== 1'b1 && lat < 64) begin
            tick();
            lat++;
        end
        check_eq("bpc4_latency", 128'(lat), 128'd4);
        check_eq("bpc4_data", b_out_state, V1_EXP);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        check_eq("bpc4_retired", 128'(b_out_valid), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
